// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - piece codes, board helpers and sequencer state encoding
package chess_pkg;

  typedef enum logic [2:0] {
    PT_EMPTY  = 3'd0,
    PT_PAWN   = 3'd1,
    PT_KNIGHT = 3'd2,
    PT_BISHOP = 3'd3,
    PT_ROOK   = 3'd4,
    PT_QUEEN  = 3'd5,
    PT_KING   = 3'd6,
    PT_RSVD   = 3'd7
  } piece_type_t;

  localparam int COLOR_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VALIDATE  = 3'd1,
    ST_CHECK     = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_WRITE     = 3'd4,
    ST_DONE      = 3'd5,
    ST_REJECT    = 3'd6,
    ST_GAME_OVER = 3'd7
  } state_t;

  function automatic logic [5:0] sq_index(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

  function automatic logic [3:0] board_slice(input logic [255:0] b, input logic [5:0] sq);
    return b[{sq, 2'b00} +: 4];
  endfunction

  // The reserved type code behaves exactly like an empty square.
  function automatic logic piece_empty(input logic [3:0] p);
    return (p[2:0] == PT_EMPTY) || (p[2:0] == PT_RSVD);
  endfunction

  function automatic logic [3:0] promote(input logic [3:0] p, input logic [2:0] row);
    if ((p[2:0] == PT_PAWN) &&
        ((!p[COLOR_BIT] && row == 3'd7) || (p[COLOR_BIT] && row == 3'd0)))
      return {p[COLOR_BIT], PT_QUEEN};
    return p;
  endfunction

endpackage

// File: rtl/square_read.sv
// rtl/square_read.sv - combinational board-to-piece mux for one square
module square_read
  import chess_pkg::*;
(
  input  logic [255:0] board,
  input  logic [5:0]   sq,
  output logic [3:0]   piece
);

  assign piece = board_slice(board, sq);

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - validates, checks and commits one chess move at a time
module move_sequencer
  import chess_pkg::*;
#(
  parameter int CHECK_TIMEOUT = 16,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_valid,
  input  logic [5:0]         move_from,
  input  logic [5:0]         move_to,
  input  logic [255:0]       board,
  input  logic               allow_valid,
  input  logic               allow_move,
  output logic               move_ready,
  output logic               check_req,
  output logic [5:0]         check_from,
  output logic [5:0]         check_to,
  output logic               write_en,
  output logic [5:0]         write_addr,
  output logic [3:0]         write_piece,
  output logic               move_done,
  output logic               move_reject,
  output logic               turn,
  output logic               game_over,
  output logic               winner,
  output logic [COUNT_W-1:0] move_count
);

  localparam int CNT_W = $clog2(CHECK_TIMEOUT + 1);

  state_t           state;
  state_t           nxt;
  logic [3:0]       src_rd;
  logic [3:0]       dst_rd;
  logic [3:0]       src_q;
  logic             dst_king_q;
  logic [CNT_W-1:0] cnt;
  logic             local_bad;

  square_read u_src (
    .board (board),
    .sq    (check_from),
    .piece (src_rd)
  );

  square_read u_dst (
    .board (board),
    .sq    (check_to),
    .piece (dst_rd)
  );

  assign local_bad = piece_empty(src_rd) ||
                     (src_rd[COLOR_BIT] != turn) ||
                     (check_from == check_to) ||
                     (!piece_empty(dst_rd) && (dst_rd[COLOR_BIT] == turn));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:      if (move_valid) nxt = ST_VALIDATE;
      ST_VALIDATE:  nxt = local_bad ? ST_REJECT : ST_CHECK;
      ST_CHECK: begin
        if (allow_valid)                          nxt = allow_move ? ST_CLEAR : ST_REJECT;
        else if (cnt == CNT_W'(CHECK_TIMEOUT - 1)) nxt = ST_REJECT;
      end
      ST_CLEAR:     nxt = ST_WRITE;
      ST_WRITE:     nxt = ST_DONE;
      ST_DONE:      nxt = dst_king_q ? ST_GAME_OVER : ST_IDLE;
      ST_REJECT:    nxt = ST_IDLE;
      ST_GAME_OVER: nxt = ST_GAME_OVER;
      default:      nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet Moore-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_ready  <= 1'b1;
      check_req   <= 1'b0;
      write_en    <= 1'b0;
      write_addr  <= '0;
      write_piece <= '0;
      move_done   <= 1'b0;
      move_reject <= 1'b0;
    end else begin
      move_ready  <= (nxt == ST_IDLE);
      check_req   <= (nxt == ST_CHECK);
      write_en    <= (nxt == ST_CLEAR) || (nxt == ST_WRITE);
      write_addr  <= (nxt == ST_CLEAR) ? check_from :
                     (nxt == ST_WRITE) ? check_to   : 6'd0;
      write_piece <= (nxt == ST_WRITE) ? promote(src_q, check_to[5:3]) : 4'h0;
      move_done   <= (nxt == ST_DONE);
      move_reject <= (nxt == ST_REJECT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_from <= '0;
      check_to   <= '0;
      src_q      <= '0;
      dst_king_q <= 1'b0;
      cnt        <= '0;
      turn       <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      move_count <= '0;
    end else begin
      if (state == ST_IDLE && move_valid) begin
        check_from <= move_from;
        check_to   <= move_to;
      end
      if (state == ST_VALIDATE) begin
        src_q      <= src_rd;
        dst_king_q <= (dst_rd[2:0] == PT_KING);
      end
      cnt <= (state == ST_CHECK) ? cnt + CNT_W'(1) : '0;
      if (state == ST_DONE) begin
        turn <= ~turn;
        if (move_count != '1) move_count <= move_count + COUNT_W'(1);
        if (dst_king_q) begin
          game_over <= 1'b1;
          winner    <= turn;
        end
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - self-checking bench for move_sequencer
module tb_move_sequencer;
  import chess_pkg::*;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         move_valid, allow_valid, allow_move;
  logic [5:0]   move_from, move_to;
  logic [255:0] board;
  logic         move_ready, check_req, write_en, move_done, move_reject;
  logic         turn, game_over, winner;
  logic [5:0]   check_from, check_to, write_addr;
  logic [3:0]   write_piece;
  logic [7:0]   move_count;

  move_sequencer #(.CHECK_TIMEOUT(TO), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_from(move_from),
    .move_to(move_to), .board(board), .allow_valid(allow_valid), .allow_move(allow_move),
    .move_ready(move_ready), .check_req(check_req), .check_from(check_from),
    .check_to(check_to), .write_en(write_en), .write_addr(write_addr),
    .write_piece(write_piece), .move_done(move_done), .move_reject(move_reject),
    .turn(turn), .game_over(game_over), .winner(winner), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0] stor [64];
  always_comb for (int i = 0; i < 64; i++) board[4*i +: 4] = stor[i];

  int done_c, rej_c, ready_c, chkreq_n, nwr, latch_bad;
  logic [5:0] wr_addr [2];
  logic [3:0] wr_piece [2];
  int wr_cyc [2];

  logic [3:0] mb [64];
  logic mt, mgo, mwin;
  int mcnt;
  int e_done, e_rej, e_ready, e_chk, e_nwr;
  logic [3:0] e_piece;

  typedef struct {
    logic [5:0] f;
    logic [5:0] t;
    int at;
    logic av;
    int rej;
    int done;
    int ready;
    int chk;
    logic turn;
    int count;
    logic [3:0] piece;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic is_empty(input logic [3:0] p);
    return (p[2:0] == 3'd0) || (p[2:0] == 3'd7);
  endfunction

  function automatic logic [3:0] start_piece(input int i);
    logic [3:0] back;
    case (i % 8)
      0, 7: back = 4'd4;
      1, 6: back = 4'd2;
      2, 5: back = 4'd3;
      3:    back = 4'd5;
      default: back = 4'd6;
    endcase
    case (i / 8)
      0: return back;
      1: return 4'h1;
      6: return 4'h9;
      7: return back | 4'h8;
      default: return 4'h0;
    endcase
  endfunction

  task automatic load_start();
    for (int i = 0; i < 64; i++) begin
      stor[i] = start_piece(i);
      mb[i] = stor[i];
    end
    mt = 1'b0; mgo = 1'b0; mwin = 1'b0; mcnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; move_valid = 1'b0; allow_valid = 1'b0; allow_move = 1'b0;
    move_from = '0; move_to = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_state(input string nm);
    chk(nm, {26'd0, move_ready, check_req, check_from, check_to, write_en, write_addr,
             write_piece, move_done, move_reject, turn, game_over, winner, move_count},
        64'h20_0000_0000);
  endtask

  // Issues a request in IDLE and follows it cycle by cycle (cycle 1 = VALIDATE).
  task automatic run_move(input logic [5:0] f, input logic [5:0] t, input int at,
                          input logic av, input logic latch_on);
    done_c = 0; rej_c = 0; ready_c = 0; chkreq_n = 0; nwr = 0; latch_bad = 0;
    move_valid = 1'b1; move_from = f; move_to = t;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      if (write_en) begin
        if (nwr < 2) begin
          wr_addr[nwr] = write_addr; wr_piece[nwr] = write_piece; wr_cyc[nwr] = c;
        end
        nwr++;
        stor[write_addr] = write_piece;
      end
      if (check_req) chkreq_n++;
      if (move_done) done_c = c;
      if (move_reject) rej_c = c;
      if (latch_on && (check_from !== f || check_to !== t)) latch_bad++;
      if (move_ready) begin
        ready_c = c;
        break;
      end
      allow_valid = (c == at);
      allow_move = (c == at) ? av : 1'($urandom);
      move_valid = ($urandom % 3 == 0);
      move_from = 6'($urandom); move_to = 6'($urandom);
      @(posedge clk); #1;
    end
    move_valid = 1'b0; allow_valid = 1'b0;
  endtask

  // Reference: the spec's acceptance rules and cycle timeline, applied to a square array.
  task automatic predict(input logic [5:0] f, input logic [5:0] t, input int at, input logic av);
    logic [3:0] s, d;
    logic lb;
    int to_row;
    s = mb[f]; d = mb[t]; to_row = int'(t) / 8;
    lb = is_empty(s) || (s[3] != mt) || (f == t) || (!is_empty(d) && d[3] == mt);
    e_done = 0; e_rej = 0; e_chk = 0; e_nwr = 0; e_piece = 4'h0; e_ready = 0;
    if (mgo) begin
      e_ready = 0;
    end else if (lb) begin
      e_rej = 2; e_ready = 3;
    end else if (at >= 2 && at < 2 + TO) begin
      e_chk = at - 1;
      if (av) begin
        e_done = at + 3; e_nwr = 2;
        e_piece = (s[2:0] == 3'd1 && ((!s[3] && to_row == 7) || (s[3] && to_row == 0)))
                  ? {s[3], 3'd5} : s;
        mb[f] = 4'h0; mb[t] = e_piece;
        if (mcnt < 255) mcnt++;
        if (d[2:0] == 3'd6) begin
          mgo = 1'b1; mwin = mt;
        end else begin
          e_ready = at + 4;
        end
        mt = ~mt;
      end else begin
        e_rej = at + 1; e_ready = at + 2;
      end
    end else begin
      e_chk = TO; e_rej = 2 + TO; e_ready = 3 + TO;
    end
  endtask

  task automatic compare_model(input logic [5:0] f, input logic [5:0] t);
    int diffs;
    chk("rnd_reject_cycle", 64'(rej_c), 64'(e_rej));
    chk("rnd_done_cycle", 64'(done_c), 64'(e_done));
    chk("rnd_ready_cycle", 64'(ready_c), 64'(e_ready));
    chk("rnd_check_req_cycles", 64'(chkreq_n), 64'(e_chk));
    chk("rnd_write_count", 64'(nwr), 64'(e_nwr));
    if (e_nwr == 2 && nwr == 2) begin
      chk("rnd_write_clear", 64'({wr_addr[0], wr_piece[0]}), 64'({f, 4'h0}));
      chk("rnd_write_dest", 64'({wr_addr[1], wr_piece[1]}), 64'({t, e_piece}));
      chk("rnd_write_cycles", 64'({wr_cyc[0], wr_cyc[1]}), 64'({e_done - 2, e_done - 1}));
    end
    diffs = 0;
    for (int i = 0; i < 64; i++) if (stor[i] !== mb[i]) diffs++;
    chk("rnd_board", 64'(diffs), 64'd0);
    chk("rnd_latch_stable", 64'(latch_bad), 64'd0);
    chk("rnd_state", 64'({turn, game_over, move_count}), 64'({mt, mgo, 8'(mcnt)}));
    if (mgo) chk("rnd_winner", 64'(winner), 64'(mwin));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    logic [5:0] f, t;
    int at;
    logic av, lon;
    int cand [$];

    vt[0]  = '{6'd12, 6'd28, 2,  1'b1, 0,  5,  6,  1,  1'b1, 1, 4'h1};
    vt[1]  = '{6'd52, 6'd36, 2,  1'b1, 2,  0,  3,  0,  1'b0, 0, 4'h0};
    vt[2]  = '{6'd12, 6'd28, 0,  1'b1, 18, 0,  19, 16, 1'b0, 0, 4'h0};
    vt[3]  = '{6'd12, 6'd28, 4,  1'b0, 5,  0,  6,  3,  1'b0, 0, 4'h0};
    vt[4]  = '{6'd12, 6'd12, 2,  1'b1, 2,  0,  3,  0,  1'b0, 0, 4'h0};
    vt[5]  = '{6'd3,  6'd11, 2,  1'b1, 2,  0,  3,  0,  1'b0, 0, 4'h0};
    vt[6]  = '{6'd20, 6'd28, 2,  1'b1, 2,  0,  3,  0,  1'b0, 0, 4'h0};
    vt[7]  = '{6'd1,  6'd18, 1,  1'b1, 18, 0,  19, 16, 1'b0, 0, 4'h0};
    vt[8]  = '{6'd1,  6'd18, 17, 1'b1, 0,  20, 21, 16, 1'b1, 1, 4'h2};
    vt[9]  = '{6'd1,  6'd18, 18, 1'b1, 18, 0,  19, 16, 1'b0, 0, 4'h0};
    vt[10] = '{6'd12, 6'd52, 2,  1'b1, 0,  5,  6,  1,  1'b1, 1, 4'h1};
    vt[11] = '{6'd60, 6'd44, 2,  1'b1, 2,  0,  3,  0,  1'b0, 0, 4'h0};

    reset = 1'b1;
    do_reset();
    check_reset_state("reset_state");

    for (int k = 0; k < 12; k++) begin
      do_reset();
      load_start();
      run_move(vt[k].f, vt[k].t, vt[k].at, vt[k].av, 1'b1);
      chk($sformatf("vec%0d_reject_cycle", k), 64'(rej_c), 64'(vt[k].rej));
      chk($sformatf("vec%0d_done_cycle", k), 64'(done_c), 64'(vt[k].done));
      chk($sformatf("vec%0d_ready_cycle", k), 64'(ready_c), 64'(vt[k].ready));
      chk($sformatf("vec%0d_check_req_cycles", k), 64'(chkreq_n), 64'(vt[k].chk));
      chk($sformatf("vec%0d_turn_count", k), 64'({turn, move_count}),
          64'({vt[k].turn, 8'(vt[k].count)}));
      chk($sformatf("vec%0d_write_count", k), 64'(nwr), (vt[k].done != 0) ? 64'd2 : 64'd0);
      if (vt[k].done != 0)
        chk($sformatf("vec%0d_board_squares", k), 64'({stor[vt[k].f], stor[vt[k].t]}),
            64'({4'h0, vt[k].piece}));
    end

    // Promotion both ways.
    do_reset();
    for (int i = 0; i < 64; i++) stor[i] = 4'h0;
    stor[4] = 4'h6; stor[60] = 4'hE; stor[48] = 4'h1; stor[8] = 4'h9;
    run_move(6'd48, 6'd56, 2, 1'b1, 1'b1);
    chk("promo_white_write", 64'({wr_addr[1], wr_piece[1]}), 64'({6'd56, 4'h5}));
    run_move(6'd8, 6'd0, 2, 1'b1, 1'b1);
    chk("promo_black_write", 64'({wr_addr[1], wr_piece[1]}), 64'({6'd0, 4'hD}));
    chk("promo_turn_count", 64'({turn, move_count}), 64'({1'b0, 8'd2}));

    // King capture freezes the game.
    do_reset();
    for (int i = 0; i < 64; i++) stor[i] = 4'h0;
    stor[4] = 4'h6; stor[52] = 4'h5; stor[60] = 4'hE;
    run_move(6'd52, 6'd60, 2, 1'b1, 1'b1);
    chk("kcap_done_cycle", 64'(done_c), 64'd5);
    chk("kcap_flags", 64'({move_ready, game_over, winner, turn, move_count}),
        64'({1'b0, 1'b1, 1'b0, 1'b1, 8'd1}));
    run_move(6'd60, 6'd52, 2, 1'b1, 1'b0);
    chk("kcap_ignored", 64'({rej_c, done_c, chkreq_n, nwr}), 64'd0);
    chk("kcap_frozen", 64'({move_ready, game_over, move_count}), 64'({1'b0, 1'b1, 8'd1}));
    do_reset();
    check_reset_state("kcap_reset_clears");

    // Reset in the middle of a commit.
    load_start();
    move_valid = 1'b1; move_from = 6'd12; move_to = 6'd28;
    @(posedge clk); #1 move_valid = 1'b0;
    @(posedge clk); #1 allow_valid = 1'b1; allow_move = 1'b1;
    @(posedge clk); #1 allow_valid = 1'b0;
    chk("midrst_clear_seen", 64'({write_en, write_addr}), 64'({1'b1, 6'd12}));
    reset = 1'b1;
    #1 check_reset_state("midrst_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (write_en) wcount++;
    end
    chk("midrst_no_writes", 64'(wcount), 64'd0);

    // Counter saturation with knights shuffling.
    do_reset();
    load_start();
    for (int k = 0; k < 258; k++) begin
      case (k % 4)
        0: run_move(6'd6, 6'd21, 2, 1'b1, 1'b1);
        1: run_move(6'd62, 6'd45, 2, 1'b1, 1'b1);
        2: run_move(6'd21, 6'd6, 2, 1'b1, 1'b1);
        default: run_move(6'd45, 6'd62, 2, 1'b1, 1'b1);
      endcase
      if (k == 254) chk("sat_count_255", 64'(move_count), 64'd255);
    end
    chk("sat_count_held", 64'(move_count), 64'd255);

    // Random requests against the reference model.
    do_reset();
    load_start();
    for (int n = 0; n < 100; n++) begin
      cand.delete();
      if ($urandom % 4 != 0)
        for (int i = 0; i < 64; i++)
          if (!is_empty(mb[i]) && mb[i][3] == mt) cand.push_back(i);
      f = (cand.size() > 0) ? 6'(cand[$urandom % cand.size()]) : 6'($urandom);
      t = 6'($urandom);
      if ($urandom % 5 == 0)
        for (int i = 0; i < 64; i++)
          if (mb[i] == {~mt, 3'd6}) t = 6'(i);
      at = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 19));
      av = ($urandom % 4 != 0);
      lon = !mgo;
      predict(f, t, at, av);
      run_move(f, t, at, av, lon);
      compare_model(f, t);
      if (mgo && ($urandom % 2 == 0)) begin
        do_reset();
        load_start();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
